// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: sweeps the codec buffer once per start pulse and streams the frame to the FFT.
// Reads are credit-limited so the (RD_LATENCY+1)-deep skid FIFO can never overflow under backpressure.
module fft_frame_sequencer #(
   parameter int ADDR_BITS  = 10,
   parameter int DATA_BITS  = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable_i,
   input  logic                 chann_sel_i,
   output logic                 chann_sel_o,
   input  logic                 buff_start_i,
   output logic [ADDR_BITS-1:0] buff_raddr_o,
   input  logic [DATA_BITS-1:0] buff_rdata_i,
   output logic [DATA_BITS-1:0] fft_data_o,
   output logic                 fft_valid_o,
   input  logic                 fft_ready_i,
   output logic                 fft_sop_o,
   output logic                 fft_eop_o,
   output logic                 frame_busy_o,
   output logic                 overrun_o,
   output logic [15:0]          frame_cnt_o
);
   localparam int DEPTH = RD_LATENCY + 1;
   localparam int PW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
   state_t state, state_nxt;
   logic [ADDR_BITS-1:0] cnt;
   logic [RD_LATENCY-1:0] pv, pf, pl;
   logic [DATA_BITS+1:0] mem [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [2:0] count;
   logic [3:0] infl, occ;
   logic pop, wr, issue, start_ok, eop_x, load;
   assign buff_raddr_o = cnt;
   assign frame_busy_o = state != IDLE;
   assign fft_valid_o = count != 3'd0;
   assign fft_data_o = fft_valid_o ? mem[rptr][DATA_BITS-1:0] : '0;
   assign fft_eop_o = fft_valid_o & mem[rptr][DATA_BITS];
   assign fft_sop_o = fft_valid_o & mem[rptr][DATA_BITS+1];
   assign pop = fft_valid_o & fft_ready_i;
   assign wr = pv[RD_LATENCY-1];
   assign start_ok = buff_start_i & enable_i;
   assign eop_x = pop & fft_eop_o;
   always_comb begin
      infl = '0;
      for (int i = 0; i < RD_LATENCY; i++) infl = infl + 4'(pv[i]);
      // a slot freed by this cycle's pop may be reused immediately, giving one beat per cycle
      occ = infl + 4'(count) - 4'(pop);
      issue = state == STREAM && occ < 4'(DEPTH);
      load = start_ok && (state == IDLE || (state == DRAIN && eop_x));
      state_nxt = state;
      state_nxt = load ? STREAM
                : (state == STREAM && issue && cnt == '1) ? DRAIN
                : (state == DRAIN && eop_x) ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         pv          <= '0;
         pf          <= '0;
         pl          <= '0;
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         chann_sel_o <= 1'b0;
         overrun_o   <= 1'b0;
         frame_cnt_o <= '0;
      end else begin
         state     <= state_nxt;
         overrun_o <= buff_start_i && (state == STREAM || (state == DRAIN && !eop_x));
         if (load) begin
            cnt         <= '0;
            chann_sel_o <= chann_sel_i;
         end else if (issue) cnt <= cnt + ADDR_BITS'(1);
         // sop/eop tags travel alongside each read so they land in the FIFO with their sample
         pv[0] <= issue;
         pf[0] <= issue && cnt == '0;
         pl[0] <= issue && cnt == '1;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pv[i] <= pv[i-1];
            pf[i] <= pf[i-1];
            pl[i] <= pl[i-1];
         end
         if (wr) wptr <= (wptr == PW'(DEPTH-1)) ? '0 : wptr + PW'(1);
         if (pop) rptr <= (rptr == PW'(DEPTH-1)) ? '0 : rptr + PW'(1);
         count <= count + 3'(wr) - 3'(pop);
         if (eop_x) frame_cnt_o <= frame_cnt_o + 16'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= {pf[RD_LATENCY-1], pl[RD_LATENCY-1], buff_rdata_i};
   end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed frame scenarios with random buffer contents and random backpressure,
// compared against the expected sample sequence of each frame.
module tb_fft_frame_sequencer;
   localparam int N = 1024;
   typedef struct {logic [15:0] d; logic s; logic e; int c;} beat_t;
   logic clk = 0, rst_n = 0, enable = 0, chann_sel = 0;
   logic start1 = 0, ready1 = 0, start3 = 0, ready3 = 0;
   logic chsel1, valid1, sop1, eop1, busy1, ovr1, chsel3, valid3, sop3, eop3, busy3, ovr3;
   logic [9:0] raddr1, raddr3;
   logic [15:0] rdata1, data1, rdata3, data3, fcnt1, fcnt3, lat1;
   logic [15:0] lat3 [3];
   logic [15:0] mem1 [N];
   logic [15:0] mem3 [N];
   beat_t got[$], got3[$];
   int cyc = 0, checks = 0, errors = 0, eops = 0, eops3 = 0, ovr_cnt = 0, ovr_cyc = -1;
   int stall_bad = 0, stall_bad3 = 0, exp_fc = 0;
   logic ph1 = 0, ph3 = 0, ps1, pe1, ps3, pe3;
   logic [15:0] pd1, pd3;

   fft_frame_sequencer #(.ADDR_BITS(10), .DATA_BITS(16), .RD_LATENCY(1)) dut (
      .clk(clk), .rst_n(rst_n), .enable_i(enable), .chann_sel_i(chann_sel), .chann_sel_o(chsel1),
      .buff_start_i(start1), .buff_raddr_o(raddr1), .buff_rdata_i(rdata1), .fft_data_o(data1),
      .fft_valid_o(valid1), .fft_ready_i(ready1), .fft_sop_o(sop1), .fft_eop_o(eop1),
      .frame_busy_o(busy1), .overrun_o(ovr1), .frame_cnt_o(fcnt1));
   fft_frame_sequencer #(.ADDR_BITS(10), .DATA_BITS(16), .RD_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .enable_i(enable), .chann_sel_i(chann_sel), .chann_sel_o(chsel3),
      .buff_start_i(start3), .buff_raddr_o(raddr3), .buff_rdata_i(rdata3), .fft_data_o(data3),
      .fft_valid_o(valid3), .fft_ready_i(ready3), .fft_sop_o(sop3), .fft_eop_o(eop3),
      .frame_busy_o(busy3), .overrun_o(ovr3), .frame_cnt_o(fcnt3));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // buffer models: data appears RD_LATENCY cycles after the address
   always @(posedge clk) begin
      lat1 <= mem1[raddr1];
      lat3[0] <= mem3[raddr3];
      lat3[1] <= lat3[0];
      lat3[2] <= lat3[1];
   end
   assign rdata1 = lat1;
   assign rdata3 = lat3[2];

   always @(negedge clk) begin
      if (valid1 && ready1) begin
         got.push_back('{data1, sop1, eop1, cyc});
         if (eop1) eops++;
      end
      if (ovr1) begin
         ovr_cnt++;
         ovr_cyc = cyc;
      end
      if (ph1 && !(valid1 && data1 == pd1 && sop1 == ps1 && eop1 == pe1)) stall_bad++;
      ph1 = valid1 && !ready1;
      pd1 = data1;
      ps1 = sop1;
      pe1 = eop1;
      if (valid3 && ready3) begin
         got3.push_back('{data3, sop3, eop3, cyc});
         if (eop3) eops3++;
      end
      if (ph3 && !(valid3 && data3 == pd3 && sop3 == ps3 && eop3 == pe3)) stall_bad3++;
      ph3 = valid3 && !ready3;
      pd3 = data3;
      ps3 = sop3;
      pe3 = eop3;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk(tag, {chsel1, raddr1, data1, valid1, sop1, eop1, busy1, ovr1, fcnt1}, 64'd0);
   endtask

   task automatic check_frame(input string tag, input bit sel, input int first_cyc, input bit contig);
      int n, bad_d, bad_f;
      beat_t b, b0, bl;
      n = sel ? got3.size() : got.size();
      bad_d = 0;
      bad_f = 0;
      for (int i = 0; i < n; i++) begin
         b = sel ? got3[i] : got[i];
         if (i >= N || b.d !== (sel ? mem3[i] : mem1[i])) bad_d++;
         if (b.s !== (i == 0) || b.e !== (i == N - 1)) bad_f++;
      end
      chk({tag, "_len"}, n, N);
      chk({tag, "_data_bad"}, bad_d, 0);
      chk({tag, "_sop_eop_bad"}, bad_f, 0);
      if (n > 0) begin
         b0 = sel ? got3[0] : got[0];
         bl = sel ? got3[n-1] : got[n-1];
         if (first_cyc >= 0) chk({tag, "_first_cycle"}, b0.c, first_cyc);
         if (contig) chk({tag, "_span"}, bl.c - b0.c, N - 1);
      end
   endtask

   task automatic start_pulse(input bit sel, output int t);
      @(posedge clk); #1;
      if (sel) start3 = 1; else start1 = 1;
      t = cyc;
      @(posedge clk); #1;
      start1 = 0;
      start3 = 0;
   endtask

   // mode 0: ready=1, 1: toggle with a 5-cycle stall at sample 500, 2: random
   task automatic drive(input int mode, input int start_cyc, output bit ok);
      int e0, stall;
      e0 = eops;
      stall = 0;
      ok = 0;
      for (int i = 0; i < 6000; i++) begin
         @(posedge clk); #1;
         start1 = (cyc == start_cyc);
         if (mode == 0) ready1 = 1;
         else if (mode == 1) begin
            if (got.size() == 500 && stall < 5) begin
               ready1 = 0;
               stall++;
            end else ready1 = i[0];
         end else ready1 = 1'($urandom_range(0, 1));
         if (eops != e0) begin
            ok = 1;
            break;
         end
      end
      start1 = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, o0, e0, f0;
      bit ok;
      for (int a = 0; a < N; a++) mem1[a] = 16'(a);
      for (int a = 0; a < N; a++) mem3[a] = 16'($urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst_n = 1;
      enable = 1;
      // 1: identity buffer, full throughput; channel change mid-frame must be ignored
      chann_sel = 1;
      ready1 = 1;
      got.delete();
      start_pulse(0, t);
      chk("t1_busy", busy1, 1);
      chk("t1_chsel", chsel1, 1);
      chann_sel = 0;
      drive(0, -1, ok);
      chk("t1_done", ok, 1);
      exp_fc++;
      check_frame("t1", 0, t + 3, 1);
      chk("t1_chsel_held", chsel1, 1);
      chk("t1_busy_after", busy1, 0);
      chk("t1_fcnt", fcnt1, exp_fc);
      // 2: toggling ready with a stall at sample 500
      for (int a = 0; a < N; a++) mem1[a] = 16'($urandom);
      got.delete();
      start_pulse(0, t);
      drive(1, -1, ok);
      chk("t2_done", ok, 1);
      exp_fc++;
      check_frame("t2", 0, -1, 0);
      chk("t2_stall_stable", stall_bad, 0);
      chk("t2_fcnt", fcnt1, exp_fc);
      chk("t2_chsel", chsel1, 0);
      // 3: second start mid-frame, random backpressure
      for (int a = 0; a < N; a++) mem1[a] = 16'($urandom);
      got.delete();
      o0 = ovr_cnt;
      start_pulse(0, t);
      drive(2, t + 100, ok);
      chk("t3_done", ok, 1);
      exp_fc++;
      check_frame("t3", 0, -1, 0);
      chk("t3_ovr_pulses", ovr_cnt - o0, 1);
      chk("t3_ovr_cycle", ovr_cyc, t + 101);
      chk("t3_idle", busy1, 0);
      chk("t3_fcnt", fcnt1, exp_fc);
      chk("t3_stall_stable", stall_bad, 0);
      // 4: restart coincident with the eop transfer
      got.delete();
      o0 = ovr_cnt;
      start_pulse(0, t);
      drive(0, t + 1026, ok);
      chk("t4a_done", ok, 1);
      exp_fc++;
      check_frame("t4a", 0, t + 3, 1);
      chk("t4_busy_restart", busy1, 1);
      got.delete();
      drive(0, -1, ok);
      chk("t4b_done", ok, 1);
      exp_fc++;
      check_frame("t4b", 0, t + 1029, 1);
      chk("t4_no_ovr", ovr_cnt - o0, 0);
      chk("t4_fcnt", fcnt1, exp_fc);
      // enable dropped mid-frame: frame completes, later starts ignored silently
      got.delete();
      start_pulse(0, t);
      enable = 0;
      drive(0, -1, ok);
      chk("en_done", ok, 1);
      exp_fc++;
      check_frame("en", 0, t + 3, 1);
      o0 = ovr_cnt;
      start_pulse(0, t);
      repeat (20) @(posedge clk);
      #1;
      chk("en_ignored", {busy1, valid1}, 0);
      chk("en_no_ovr", ovr_cnt - o0, 0);
      chk("en_fcnt", fcnt1, exp_fc);
      enable = 1;
      // 5: reset at sample 300
      got.delete();
      ready1 = 1;
      start_pulse(0, t);
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (got.size() >= 300) begin
            ok = 1;
            break;
         end
      end
      chk("t5_reach300", ok, 1);
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      check_zero("t5_rst_mid");
      e0 = eops;
      repeat (30) @(posedge clk);
      #1;
      chk("t5_no_eop", eops - e0, 0);
      chk("t5_fcnt0", fcnt1, 0);
      exp_fc = 0;
      got.delete();
      start_pulse(0, t);
      drive(0, -1, ok);
      chk("t5_done", ok, 1);
      exp_fc++;
      check_frame("t5", 0, t + 3, 1);
      chk("t5_fcnt", fcnt1, exp_fc);
      // 6: RD_LATENCY=3 instance held off for 20 cycles
      got3.delete();
      ready3 = 0;
      f0 = fcnt3;
      start_pulse(1, t);
      repeat (20) @(posedge clk);
      #1;
      chk("t6_reads_le_4", 64'(raddr3 <= 10'd4), 1);
      chk("t6_head", {valid3, sop3, data3}, {1'b1, 1'b1, mem3[0]});
      e0 = eops3;
      ok = 0;
      for (int i = 0; i < 6000; i++) begin
         @(posedge clk); #1;
         ready3 = 1'($urandom_range(0, 1));
         if (eops3 != e0) begin
            ok = 1;
            break;
         end
      end
      chk("t6_done", ok, 1);
      check_frame("t6", 1, -1, 0);
      chk("t6_stall_stable", stall_bad3, 0);
      chk("t6_fcnt", fcnt3, f0 + 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
